// File: rtl/rx_tmp_buf_slab_alloc_if.sv
// Allocator bus: alloc request/grant handshake, slab free path and status.
// master = consumer side, slave = allocator side.
interface rx_tmp_buf_slab_alloc_if #(
    parameter int NUM_SLABS  = 2,
    parameter int SLAB_BYTES = 9152
);
    localparam int SLAB_NUM_W   = $clog2(NUM_SLABS);
    localparam int SLAB_BYTES_W = $clog2(SLAB_BYTES);
    localparam int ADDR_W       = SLAB_NUM_W + SLAB_BYTES_W;
    localparam int CNT_W        = $clog2(NUM_SLABS + 1);

    logic                  alloc_req_val;
    logic                  alloc_req_rdy;
    logic                  alloc_resp_val;
    logic [SLAB_NUM_W-1:0] alloc_resp_slab;
    logic [ADDR_W-1:0]     alloc_resp_addr;
    logic                  alloc_resp_rdy;
    logic                  free_req_val;
    logic [SLAB_NUM_W-1:0] free_req_slab;
    logic                  free_req_rdy;
    logic [CNT_W-1:0]      free_cnt;
    logic                  err_bad_free;

    modport master (
        output alloc_req_val, alloc_resp_rdy, free_req_val, free_req_slab,
        input  alloc_req_rdy, alloc_resp_val, alloc_resp_slab, alloc_resp_addr,
               free_req_rdy, free_cnt, err_bad_free
    );

    modport slave (
        input  alloc_req_val, alloc_resp_rdy, free_req_val, free_req_slab,
        output alloc_req_rdy, alloc_resp_val, alloc_resp_slab, alloc_resp_addr,
               free_req_rdy, free_cnt, err_bad_free
    );
endinterface

// File: rtl/rx_tmp_buf_slab_alloc.sv
// RX temp-buffer slab allocator: free bitmap, lowest-index grant, one grant
// outstanding, free path with illegal-free detection.
// Optional macro SLAB_ALLOC_STATS_EN adds the alloc_stall_cnt output.
module rx_tmp_buf_slab_alloc #(
    parameter int NUM_SLABS  = 2,
    parameter int SLAB_BYTES = 9152
) (
    input logic clk,
    input logic rst,
    rx_tmp_buf_slab_alloc_if.slave bus
`ifdef SLAB_ALLOC_STATS_EN
    ,
    output logic [31:0] alloc_stall_cnt
`endif
);
    localparam int SLAB_NUM_W   = $clog2(NUM_SLABS);
    localparam int SLAB_BYTES_W = $clog2(SLAB_BYTES);
    localparam int CNT_W        = $clog2(NUM_SLABS + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;

    logic [0:0]            r_state;
    logic [NUM_SLABS-1:0]  r_bitmap;
    logic [CNT_W-1:0]      r_free_cnt;
    logic [SLAB_NUM_W-1:0] r_resp_slab;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_inrange;
    logic                  w_hit;
    logic                  w_free_ok;
    logic [SLAB_NUM_W-1:0] w_lowest;
    logic [NUM_SLABS-1:0]  w_free_mask;
    logic [NUM_SLABS-1:0]  w_alloc_mask;

    assign bus.alloc_req_rdy   = !rst && (r_state == IDLE) && (r_free_cnt != '0);
    assign bus.alloc_resp_val  = (r_state == RESP);
    assign bus.alloc_resp_slab = r_resp_slab;
    assign bus.alloc_resp_addr = {r_resp_slab, {SLAB_BYTES_W{1'b0}}};
    assign bus.free_req_rdy    = !rst;
    assign bus.free_cnt        = r_free_cnt;
    assign bus.err_bad_free    = r_err;

    assign w_accept  = bus.alloc_req_val && bus.alloc_req_rdy;
    assign w_free_ok = bus.free_req_val && w_inrange && !w_hit;

    // Lowest free slab, free-index decode and the bitmap set/clear masks.
    // Selection works on the current bitmap, so a slab freed this cycle is
    // not eligible until the next one.
    always_comb begin
        w_lowest     = '0;
        w_inrange    = 1'b0;
        w_hit        = 1'b0;
        w_free_mask  = '0;
        w_alloc_mask = '0;
        for (int i = NUM_SLABS - 1; i >= 0; i--) begin
            if (r_bitmap[i]) w_lowest = SLAB_NUM_W'(i);
        end
        for (int i = 0; i < NUM_SLABS; i++) begin
            if (bus.free_req_slab == SLAB_NUM_W'(i)) begin
                w_inrange = 1'b1;
                w_hit     = r_bitmap[i];
            end
        end
        for (int i = 0; i < NUM_SLABS; i++) begin
            w_free_mask[i]  = w_free_ok && (bus.free_req_slab == SLAB_NUM_W'(i));
            w_alloc_mask[i] = w_accept && (w_lowest == SLAB_NUM_W'(i));
        end
    end

    // Bitmap, free count and bad-free pulse. The allocated slab is free and
    // the freed one busy, so the two masks never overlap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bitmap   <= '1;
            r_free_cnt <= CNT_W'(NUM_SLABS);
            r_err      <= 1'b0;
        end else begin
            r_bitmap <= (r_bitmap & ~w_alloc_mask) | w_free_mask;
            r_err    <= bus.free_req_val && !w_free_ok;
            if (w_accept && !w_free_ok)
                r_free_cnt <= r_free_cnt - CNT_W'(1);
            else if (!w_accept && w_free_ok)
                r_free_cnt <= r_free_cnt + CNT_W'(1);
        end
    end

    // Grant FSM: capture the slab on accept, hold it until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_resp_slab <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_state     <= RESP;
                    r_resp_slab <= w_lowest;
                end
                RESP: if (bus.alloc_resp_rdy) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SLAB_ALLOC_STATS_EN
    logic [31:0] r_stall_cnt;
    assign alloc_stall_cnt = r_stall_cnt;

    // Count cycles a request waits in IDLE with the pool empty, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (bus.alloc_req_val && (r_state == IDLE) && (r_free_cnt == '0) &&
                 (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_rx_tmp_buf_slab_alloc.sv
// Bench for rx_tmp_buf_slab_alloc: directed scenarios on a 2-slab instance,
// out-of-range free and randomized traffic on a 5-slab instance checked
// against a slab-array reference model.
module tb_rx_tmp_buf_slab_alloc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rx_tmp_buf_slab_alloc_if #(.NUM_SLABS(2), .SLAB_BYTES(9152)) ifa ();
    rx_tmp_buf_slab_alloc_if #(.NUM_SLABS(5), .SLAB_BYTES(9152)) ifb ();

`ifdef SLAB_ALLOC_STATS_EN
    logic [31:0] stall_a, stall_b;
    rx_tmp_buf_slab_alloc #(.NUM_SLABS(2), .SLAB_BYTES(9152)) u_a (
        .clk(clk), .rst(rst), .bus(ifa), .alloc_stall_cnt(stall_a));
    rx_tmp_buf_slab_alloc #(.NUM_SLABS(5), .SLAB_BYTES(9152)) u_b (
        .clk(clk), .rst(rst), .bus(ifb), .alloc_stall_cnt(stall_b));
`else
    rx_tmp_buf_slab_alloc #(.NUM_SLABS(2), .SLAB_BYTES(9152)) u_a (
        .clk(clk), .rst(rst), .bus(ifa));
    rx_tmp_buf_slab_alloc #(.NUM_SLABS(5), .SLAB_BYTES(9152)) u_b (
        .clk(clk), .rst(rst), .bus(ifb));
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ck(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        ifa.alloc_req_val = 0; ifa.alloc_resp_rdy = 0; ifa.free_req_val = 0; ifa.free_req_slab = 0;
        ifb.alloc_req_val = 0; ifb.alloc_resp_rdy = 0; ifb.free_req_val = 0; ifb.free_req_slab = 0;
        rst = 1'b1;
        #12;
        checks++; if (ifa.alloc_req_rdy !== 1'b0) begin failures++; $display("FAIL rst_req_rdy: got %b want 0", ifa.alloc_req_rdy); end
        checks++; if (ifa.free_req_rdy !== 1'b0) begin failures++; $display("FAIL rst_free_rdy: got %b want 0", ifa.free_req_rdy); end
        checks++; if (ifa.free_cnt !== 2'd2) begin failures++; $display("FAIL rst_cnt: got %0d want 2", ifa.free_cnt); end
        checks++; if (ifa.alloc_resp_val !== 1'b0) begin failures++; $display("FAIL rst_val: got %b want 0", ifa.alloc_resp_val); end
        checks++; if (ifa.err_bad_free !== 1'b0) begin failures++; $display("FAIL rst_err: got %b want 0", ifa.err_bad_free); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (ifa.alloc_req_rdy !== 1'b1) begin failures++; $display("FAIL post_rst_req_rdy: got %b want 1", ifa.alloc_req_rdy); end
        checks++; if (ifa.free_req_rdy !== 1'b1) begin failures++; $display("FAIL post_rst_free_rdy: got %b want 1", ifa.free_req_rdy); end
        checks++; if (ifa.free_cnt !== 2'd2) begin failures++; $display("FAIL post_rst_cnt: got %0d want 2", ifa.free_cnt); end
        checks++; if (ifb.free_cnt !== 3'd5) begin failures++; $display("FAIL post_rst_cnt_b: got %0d want 5", ifb.free_cnt); end
    endtask

    task automatic test_back_to_back();
        ifa.alloc_req_val = 1; ifa.alloc_resp_rdy = 1;
        tick();
        checks++; if (ifa.alloc_resp_val !== 1'b1 || ifa.alloc_resp_slab !== 1'b0 || ifa.alloc_resp_addr !== 15'h0000)
            begin failures++; $display("FAIL b2b_grant0: got val=%b slab=%0d addr=%h want 1/0/0000", ifa.alloc_resp_val, ifa.alloc_resp_slab, ifa.alloc_resp_addr); end
        checks++; if (ifa.free_cnt !== 2'd1 || ifa.alloc_req_rdy !== 1'b0)
            begin failures++; $display("FAIL b2b_resp0: got cnt=%0d rdy=%b want 1/0", ifa.free_cnt, ifa.alloc_req_rdy); end
        tick();
        checks++; if (ifa.alloc_resp_val !== 1'b0 || ifa.alloc_req_rdy !== 1'b1)
            begin failures++; $display("FAIL b2b_take0: got val=%b rdy=%b want 0/1", ifa.alloc_resp_val, ifa.alloc_req_rdy); end
        tick();
        checks++; if (ifa.alloc_resp_val !== 1'b1 || ifa.alloc_resp_slab !== 1'b1 || ifa.alloc_resp_addr !== 15'h4000)
            begin failures++; $display("FAIL b2b_grant1: got val=%b slab=%0d addr=%h want 1/1/4000", ifa.alloc_resp_val, ifa.alloc_resp_slab, ifa.alloc_resp_addr); end
        checks++; if (ifa.free_cnt !== 2'd0) begin failures++; $display("FAIL b2b_cnt0: got %0d want 0", ifa.free_cnt); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ifa.alloc_req_rdy !== 1'b0 || ifa.alloc_resp_val !== 1'b0)
                begin failures++; $display("FAIL b2b_stall: got rdy=%b val=%b want 0/0", ifa.alloc_req_rdy, ifa.alloc_resp_val); end
        end
        ifa.alloc_req_val = 0;
    endtask

    task automatic test_free_same_cycle();
        ifa.free_req_val = 1; ifa.free_req_slab = 1; ifa.alloc_req_val = 1;
        #1;
        checks++; if (ifa.alloc_req_rdy !== 1'b0) begin failures++; $display("FAIL fsc_no_accept: got %b want 0", ifa.alloc_req_rdy); end
        tick();
        ifa.free_req_val = 0;
        checks++; if (ifa.free_cnt !== 2'd1 || ifa.alloc_resp_val !== 1'b0 || ifa.alloc_req_rdy !== 1'b1)
            begin failures++; $display("FAIL fsc_freed: got cnt=%0d val=%b rdy=%b want 1/0/1", ifa.free_cnt, ifa.alloc_resp_val, ifa.alloc_req_rdy); end
        tick();
        ifa.alloc_req_val = 0;
        checks++; if (ifa.alloc_resp_val !== 1'b1 || ifa.alloc_resp_slab !== 1'b1 || ifa.free_cnt !== 2'd0)
            begin failures++; $display("FAIL fsc_grant1: got val=%b slab=%0d cnt=%0d want 1/1/0", ifa.alloc_resp_val, ifa.alloc_resp_slab, ifa.free_cnt); end
        tick();
        ifa.free_req_val = 1; ifa.free_req_slab = 0;
        tick();
        ifa.free_req_slab = 1;
        tick();
        ifa.free_req_val = 0;
        checks++; if (ifa.free_cnt !== 2'd2 || ifa.err_bad_free !== 1'b0)
            begin failures++; $display("FAIL fsc_restore: got cnt=%0d err=%b want 2/0", ifa.free_cnt, ifa.err_bad_free); end
    endtask

    task automatic test_bad_free();
        ifa.free_req_val = 1; ifa.free_req_slab = 0;
        ifb.free_req_val = 1; ifb.free_req_slab = 3'd6;
        tick();
        ifa.free_req_val = 0; ifb.free_req_val = 0;
        checks++; if (ifa.err_bad_free !== 1'b1 || ifa.free_cnt !== 2'd2)
            begin failures++; $display("FAIL bad_double: got err=%b cnt=%0d want 1/2", ifa.err_bad_free, ifa.free_cnt); end
        checks++; if (ifb.err_bad_free !== 1'b1 || ifb.free_cnt !== 3'd5)
            begin failures++; $display("FAIL bad_range: got err=%b cnt=%0d want 1/5", ifb.err_bad_free, ifb.free_cnt); end
        tick();
        checks++; if (ifa.err_bad_free !== 1'b0 || ifb.err_bad_free !== 1'b0)
            begin failures++; $display("FAIL bad_pulse: got a=%b b=%b want 0/0", ifa.err_bad_free, ifb.err_bad_free); end
    endtask

    task automatic test_concurrent();
        ifa.alloc_req_val = 1; ifa.alloc_resp_rdy = 1;
        tick();
        ifa.alloc_req_val = 0;
        tick();
        ifa.alloc_req_val = 1; ifa.free_req_val = 1; ifa.free_req_slab = 0;
        tick();
        checks++; if (ifa.alloc_resp_val !== 1'b1 || ifa.alloc_resp_slab !== 1'b1 || ifa.free_cnt !== 2'd1)
            begin failures++; $display("FAIL conc_preupdate: got val=%b slab=%0d cnt=%0d want 1/1/1", ifa.alloc_resp_val, ifa.alloc_resp_slab, ifa.free_cnt); end
        ifa.alloc_req_val = 0; ifa.free_req_slab = 1; ifa.alloc_resp_rdy = 0;
        tick();
        checks++; if (ifa.alloc_resp_val !== 1'b1 || ifa.alloc_resp_slab !== 1'b1 || ifa.free_cnt !== 2'd2 || ifa.err_bad_free !== 1'b0)
            begin failures++; $display("FAIL conc_free_held: got val=%b slab=%0d cnt=%0d err=%b want 1/1/2/0", ifa.alloc_resp_val, ifa.alloc_resp_slab, ifa.free_cnt, ifa.err_bad_free); end
        ifa.free_req_val = 0; ifa.alloc_resp_rdy = 1;
        tick();
        ifa.alloc_resp_rdy = 0;
        checks++; if (ifa.alloc_resp_val !== 1'b0 || ifa.free_cnt !== 2'd2)
            begin failures++; $display("FAIL conc_done: got val=%b cnt=%0d want 0/2", ifa.alloc_resp_val, ifa.free_cnt); end
    endtask

    task automatic test_reset_mid_resp();
        ifa.alloc_req_val = 1; ifa.alloc_resp_rdy = 0;
        tick();
        ifa.alloc_req_val = 0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (ifa.alloc_resp_val !== 1'b1 || ifa.alloc_resp_slab !== 1'b0 || ifa.free_cnt !== 2'd1)
                begin failures++; $display("FAIL hold: got val=%b slab=%0d cnt=%0d want 1/0/1", ifa.alloc_resp_val, ifa.alloc_resp_slab, ifa.free_cnt); end
            tick();
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (ifa.alloc_resp_val !== 1'b0 || ifa.free_cnt !== 2'd2 || ifa.alloc_req_rdy !== 1'b0)
            begin failures++; $display("FAIL async_rst: got val=%b cnt=%0d rdy=%b want 0/2/0", ifa.alloc_resp_val, ifa.free_cnt, ifa.alloc_req_rdy); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (ifa.alloc_req_rdy !== 1'b1) begin failures++; $display("FAIL rst_release: got %b want 1", ifa.alloc_req_rdy); end
    endtask

`ifdef SLAB_ALLOC_STATS_EN
    task automatic test_stats();
        checks++; if (stall_a !== 32'd0) begin failures++; $display("FAIL stall_init: got %0d want 0", stall_a); end
        ifa.alloc_req_val = 1; ifa.alloc_resp_rdy = 1;
        repeat (4) tick();
        repeat (10) tick();
        ifa.alloc_req_val = 0;
        checks++; if (stall_a !== 32'd10) begin failures++; $display("FAIL stall_cnt: got %0d want 10", stall_a); end
        ifa.alloc_resp_rdy = 0;
    endtask
`endif

    // Reference: per-slab free flags, one optional outstanding grant.
    task automatic test_random(input int cycles);
        bit m_free[5];
        bit m_out = 0;
        int m_slab = 0;
        bit m_err = 0;
        int cnt, lo;
        bit rv, rr, fv, ok, exp_rdy;
        int fi;
        for (int i = 0; i < 5; i++) m_free[i] = 1;
        for (int c = 0; c < cycles; c++) begin
            cnt = 0;
            for (int i = 0; i < 5; i++) cnt += m_free[i];
            exp_rdy = !m_out && cnt > 0;
            checks++; if (ifb.free_cnt !== 3'(cnt)) begin failures++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, ifb.free_cnt, cnt); end
            checks++; if (ifb.alloc_req_rdy !== exp_rdy) begin failures++; $display("FAIL rnd_rdy c%0d: got %b want %b", c, ifb.alloc_req_rdy, exp_rdy); end
            checks++; if (ifb.alloc_resp_val !== m_out) begin failures++; $display("FAIL rnd_val c%0d: got %b want %b", c, ifb.alloc_resp_val, m_out); end
            checks++; if (ifb.err_bad_free !== m_err) begin failures++; $display("FAIL rnd_err c%0d: got %b want %b", c, ifb.err_bad_free, m_err); end
            if (m_out) begin
                checks++; if (ifb.alloc_resp_slab !== 3'(m_slab) || ifb.alloc_resp_addr !== 17'(m_slab * 16384))
                    begin failures++; $display("FAIL rnd_grant c%0d: got slab=%0d addr=%h want %0d/%h", c, ifb.alloc_resp_slab, ifb.alloc_resp_addr, m_slab, m_slab * 16384); end
            end
            rv = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 3) != 0);
            fv = ($urandom_range(0, 2) == 0);
            fi = $urandom_range(0, 7);
            ifb.alloc_req_val = rv; ifb.alloc_resp_rdy = rr;
            ifb.free_req_val = fv; ifb.free_req_slab = 3'(fi);
            lo = -1;
            for (int i = 4; i >= 0; i--) if (m_free[i]) lo = i;
            ok = fv && fi < 5 && !m_free[fi];
            m_err = fv && !ok;
            if (m_out && rr) m_out = 0;
            else if (rv && exp_rdy) begin m_free[lo] = 0; m_out = 1; m_slab = lo; end
            if (ok) m_free[fi] = 1;
            tick();
        end
        ifb.alloc_req_val = 0; ifb.free_req_val = 0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_free_same_cycle();
        test_bad_free();
        test_concurrent();
        test_reset_mid_resp();
`ifdef SLAB_ALLOC_STATS_EN
        test_stats();
        test_reset_mid_resp();
`endif
        test_random(2000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
